// File: rtl/icache_pkg.sv
// icache_pkg: shared state encoding, AXI length width and line-offset helper for the icache controller
package icache_pkg;
  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_A, MISS_R, REFILL, CACOP} state_t;
  localparam int AXI_LEN_W = 8;
  function automatic int off_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction
endpackage

// File: rtl/icache_ctrl_nway_if.sv
// icache_ctrl_nway_if: AXI-style read address/data channel between icache controller and read master
interface icache_ctrl_nway_if #(parameter int ADDR_W = 32);
  import icache_pkg::*;
  logic                 i_arvalid;
  logic                 i_arready;
  logic [ADDR_W-1:0]    i_araddr;
  logic [AXI_LEN_W-1:0] i_arlen;
  logic                 i_rvalid;
  logic                 i_rready;
  logic                 i_rlast;
  modport master (output i_arvalid, i_araddr, i_arlen, i_rready, input i_arready, i_rvalid, i_rlast);
  modport slave (input i_arvalid, i_araddr, i_arlen, i_rready, output i_arready, i_rvalid, i_rlast);
endinterface

// File: rtl/icache_beat_cnt.sv
// icache_beat_cnt: refill beat counter that saturates once a full line has been written
module icache_beat_cnt #(parameter int LINE_WORDS = 4) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          inc,
  output logic [$clog2(LINE_WORDS)-1:0] idx,
  output logic                          sat
);
  localparam int IW = $clog2(LINE_WORDS);
  logic [IW:0] cnt;
  // count accepted beats, holding at LINE_WORDS so surplus beats never wrap onto word 0
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !sat) cnt <= cnt + 1'b1;
  assign sat = cnt[IW];
  assign idx = cnt[IW-1:0];
endmodule

// File: rtl/icache_ctrl_nway.sv
// icache_ctrl_nway: N-way icache control FSM (lookup, burst refill, uncached fetch; CACOP invalidate when ICACHE_CACOP_EN is defined)
module icache_ctrl_nway import icache_pkg::*; #(
  parameter int NUM_WAYS   = 2,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rvalid,
  output logic                          rready,
  input  logic [ADDR_W-1:0]             addr,
  input  logic                          uncache,
  input  logic [NUM_WAYS-1:0]           hit,
  input  logic [NUM_WAYS-1:0]           repl_way,
  icache_ctrl_nway_if.master            axi,
  output logic                          fbuf_we,
  output logic [$clog2(LINE_WORDS)-1:0] fbuf_idx,
  output logic                          fbuf_clear,
  output logic                          rbuf_we,
  output logic                          data_from_mem_sel,
  output logic [NUM_WAYS-1:0]           mem_we,
  output logic [NUM_WAYS-1:0]           tagv_we,
  output logic                          tagv_clr,
  output logic                          lru_update,
  output logic [NUM_WAYS-1:0]           lru_way,
  input  logic                          cacop_req,
  input  logic [NUM_WAYS-1:0]           cacop_way,
  output logic                          cacop_ack
);
  localparam int OW = off_w(LINE_WORDS);
  state_t                 state;
  logic [ADDR_W-1:0]      araddr_q;
  logic [AXI_LEN_W-1:0]   arlen_q;
  logic [NUM_WAYS-1:0]    way_q;
  logic                   unc_q;
  logic                   hit_any;
  logic                   cacop_go;
  logic                   sat;
  logic                   unused_addr;
  assign hit_any     = |hit;
  assign unused_addr = ^addr[1:0];
`ifdef ICACHE_CACOP_EN
  assign cacop_go = cacop_req;
`else
  logic unused_cacop;
  assign cacop_go     = 1'b0;
  assign unused_cacop = ^{cacop_req, cacop_way};
`endif
  assign axi.i_araddr = araddr_q;
  assign axi.i_arlen  = arlen_q;
  icache_beat_cnt #(.LINE_WORDS(LINE_WORDS)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state != MISS_R),
    .inc (state == MISS_R && axi.i_rvalid),
    .idx (fbuf_idx),
    .sat (sat)
  );
  // state sequencing; a miss captures the burst address/length, victim way and uncached flag on leaving LOOKUP
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      araddr_q <= '0;
      arlen_q  <= '0;
      way_q    <= '0;
      unc_q    <= 1'b0;
    end else begin
      case (state)
        IDLE:   state <= cacop_go ? CACOP : rvalid ? LOOKUP : IDLE;
        LOOKUP: if (uncache || !hit_any) begin
          state    <= MISS_A;
          araddr_q <= uncache ? {addr[ADDR_W-1:2], 2'b0} : {addr[ADDR_W-1:OW], {OW{1'b0}}};
          arlen_q  <= uncache ? '0 : AXI_LEN_W'(LINE_WORDS - 1);
          way_q    <= repl_way;
          unc_q    <= uncache;
        end else state <= rvalid ? LOOKUP : IDLE;
        MISS_A: if (axi.i_arready) state <= MISS_R;
        MISS_R: if (axi.i_rvalid && axi.i_rlast) state <= unc_q ? IDLE : REFILL;
        default: state <= IDLE;
      endcase
    end
  // output decode from state and live inputs; anything not driven in a state stays 0
  always_comb begin
    rready            = 1'b0;
    rbuf_we           = 1'b0;
    fbuf_clear        = 1'b0;
    fbuf_we           = 1'b0;
    data_from_mem_sel = 1'b0;
    mem_we            = '0;
    tagv_we           = '0;
    tagv_clr          = 1'b0;
    lru_update        = 1'b0;
    lru_way           = '0;
    cacop_ack         = 1'b0;
    axi.i_arvalid     = 1'b0;
    axi.i_rready      = 1'b0;
    case (state)
      IDLE: begin
        rready     = 1'b1;
        rbuf_we    = 1'b1;
        fbuf_clear = 1'b1;
      end
      LOOKUP: if (!uncache && hit_any) begin
        rready     = 1'b1;
        rbuf_we    = 1'b1;
        fbuf_clear = 1'b1;
        lru_update = 1'b1;
        lru_way    = hit;
      end
      MISS_A: axi.i_arvalid = 1'b1;
      MISS_R: begin
        axi.i_rready      = 1'b1;
        fbuf_we           = axi.i_rvalid && !sat;
        rready            = axi.i_rvalid && axi.i_rlast && unc_q;
        data_from_mem_sel = axi.i_rvalid && axi.i_rlast && unc_q;
      end
      REFILL: begin
        mem_we            = way_q;
        tagv_we           = way_q;
        rready            = 1'b1;
        data_from_mem_sel = 1'b1;
        lru_update        = 1'b1;
        lru_way           = way_q;
      end
`ifdef ICACHE_CACOP_EN
      CACOP: begin
        tagv_we   = cacop_way;
        tagv_clr  = 1'b1;
        cacop_ack = 1'b1;
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_icache_ctrl_nway.sv
// tb_icache_ctrl_nway: table-driven and scoreboarded checks of icache_ctrl_nway with 4 ways and 4-word lines
module tb_icache_ctrl_nway;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  logic        clk, rst, rvalid, uncache, cacop_req;
  logic [31:0] addr;
  logic [3:0]  hit, repl_way, cacop_way;
  logic        rready, fbuf_we, fbuf_clear, rbuf_we, dfms, tagv_clr, lru_update, cacop_ack;
  logic [1:0]  fbuf_idx;
  logic [3:0]  mem_we, tagv_we, lru_way;
  logic [21:0] obs, idle_o, zero_o, ar_o;
  logic [1:0]  sb[$];
  int          n_vec = 0, n_bad = 0;

  typedef struct { logic rv; logic [3:0] hit; logic [21:0] exp; } vec_t;
  vec_t tbl[9];

  icache_ctrl_nway_if #(.ADDR_W(32)) axi ();

  icache_ctrl_nway #(.NUM_WAYS(4), .LINE_WORDS(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rvalid(rvalid), .rready(rready), .addr(addr), .uncache(uncache),
    .hit(hit), .repl_way(repl_way), .axi(axi), .fbuf_we(fbuf_we), .fbuf_idx(fbuf_idx),
    .fbuf_clear(fbuf_clear), .rbuf_we(rbuf_we), .data_from_mem_sel(dfms), .mem_we(mem_we),
    .tagv_we(tagv_we), .tagv_clr(tagv_clr), .lru_update(lru_update), .lru_way(lru_way),
    .cacop_req(cacop_req), .cacop_way(cacop_way), .cacop_ack(cacop_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {rready, rbuf_we, fbuf_clear, lru_update, lru_way, axi.i_arvalid, dfms,
                mem_we, tagv_we, tagv_clr, cacop_ack, fbuf_we, axi.i_rready};

  function automatic logic [21:0] eo(input logic rr, rb, fc, lu, input logic [3:0] lw,
                                     input logic av, dm, input logic [3:0] mw, tw,
                                     input logic tc, ca, fw, ir);
    return {rr, rb, fc, lu, lw, av, dm, mw, tw, tc, ca, fw, ir};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_idx(input string nm);
    logic [1:0] e;
    e = 2'bxx;
    if (sb.size() > 0) e = sb.pop_front();
    chk(nm, 32'(fbuf_idx), 32'(e));
  endtask

  task automatic miss(input logic [31:0] a, input logic [3:0] w, input int dly, input int nb,
                      input logic [31:0] ea);
    addr = a; repl_way = w; rvalid = 1'b1; hit = 4'h0; uncache = 1'b0;
    #1 chk("m_idle", 32'(obs), 32'(idle_o));
    @(negedge clk);
    rvalid = 1'b0;
    #1 chk("m_lookup", 32'(obs), 32'(zero_o));
    @(negedge clk);
    for (int d = 0; d <= dly; d++) begin
      axi.i_arready = (d == dly);
      axi.i_rvalid  = (d != dly);
      axi.i_rlast   = (d != dly);
      #1 chk("araddr", axi.i_araddr, ea);
      chk("arlen", 32'(axi.i_arlen), 32'd3);
      chk("miss_a", 32'(obs), 32'(ar_o));
      @(negedge clk);
    end
    axi.i_arready = 1'b0;
    for (int k = 0; k < nb; k++) begin
      axi.i_rvalid = 1'b1;
      axi.i_rlast  = (k == nb - 1);
      if (k < 4) sb.push_back(2'(k));
      #1 chk("beat", 32'(obs), 32'(eo(L, L, L, L, 4'h0, L, L, 4'h0, 4'h0, L, L, k < 4, H)));
      if (fbuf_we) chk_idx("fbuf_idx");
      @(negedge clk);
    end
    axi.i_rvalid = 1'b0;
    axi.i_rlast  = 1'b0;
    #1 chk("refill", 32'(obs), 32'(eo(H, L, L, H, w, L, H, w, w, L, L, L, L)));
    chk("sb_drain", 32'(sb.size()), 32'd0);
    @(negedge clk);
    #1 chk("m_done", 32'(obs), 32'(idle_o));
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_o = eo(H, H, H, L, 4'h0, L, L, 4'h0, 4'h0, L, L, L, L);
    zero_o = eo(L, L, L, L, 4'h0, L, L, 4'h0, 4'h0, L, L, L, L);
    ar_o   = eo(L, L, L, L, 4'h0, H, L, 4'h0, 4'h0, L, L, L, L);
    tbl[0] = '{H, 4'h0, idle_o};
    tbl[1] = '{H, 4'b0100, eo(H, H, H, H, 4'b0100, L, L, 4'h0, 4'h0, L, L, L, L)};
    tbl[2] = '{H, 4'b0100, eo(H, H, H, H, 4'b0100, L, L, 4'h0, 4'h0, L, L, L, L)};
    tbl[3] = '{L, 4'b0100, eo(H, H, H, H, 4'b0100, L, L, 4'h0, 4'h0, L, L, L, L)};
    tbl[4] = '{L, 4'h0, idle_o};
    tbl[5] = '{H, 4'h0, idle_o};
    tbl[6] = '{H, 4'b0001, eo(H, H, H, H, 4'b0001, L, L, 4'h0, 4'h0, L, L, L, L)};
    tbl[7] = '{L, 4'b1000, eo(H, H, H, H, 4'b1000, L, L, 4'h0, 4'h0, L, L, L, L)};
    tbl[8] = '{L, 4'h0, idle_o};

    rst = 1'b1; rvalid = 1'b1; uncache = 1'b0; hit = 4'h0; repl_way = 4'h0;
    cacop_req = 1'b0; cacop_way = 4'h0; addr = 32'h1C00_0100;
    axi.i_arready = 1'b0; axi.i_rvalid = 1'b0; axi.i_rlast = 1'b0;
    #2 chk("reset", 32'(obs), 32'(idle_o));
    @(negedge clk);
    chk("reset_hold", 32'(obs), 32'(idle_o));
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      rvalid = tbl[i].rv;
      hit    = tbl[i].hit;
      #1 chk($sformatf("vec%0d", i), 32'(obs), 32'(tbl[i].exp));
      @(negedge clk);
    end
    rvalid = 1'b0; hit = 4'h0;

    miss(32'h1C00_0234, 4'b0010, 2, 4, 32'h1C00_0230);

    addr = 32'hBFAF_F006; rvalid = 1'b1;
    #1 chk("u_idle", 32'(obs), 32'(idle_o));
    @(negedge clk);
    rvalid = 1'b0; uncache = 1'b1; hit = 4'b0010;
    #1 chk("u_lookup", 32'(obs), 32'(zero_o));
    @(negedge clk);
    uncache = 1'b0; hit = 4'h0; axi.i_arready = 1'b1;
    #1 chk("u_araddr", axi.i_araddr, 32'hBFAF_F004);
    chk("u_arlen", 32'(axi.i_arlen), 32'd0);
    chk("u_miss_a", 32'(obs), 32'(ar_o));
    @(negedge clk);
    axi.i_arready = 1'b0; axi.i_rvalid = 1'b1; axi.i_rlast = 1'b1;
    sb.push_back(2'd0);
    #1 chk("u_beat", 32'(obs), 32'(eo(H, L, L, L, 4'h0, L, H, 4'h0, 4'h0, L, L, H, H)));
    chk_idx("u_idx");
    @(negedge clk);
    axi.i_rvalid = 1'b0; axi.i_rlast = 1'b0;
    #1 chk("u_no_refill", 32'(obs), 32'(idle_o));
    @(negedge clk);

    addr = 32'h0000_0040; repl_way = 4'b0100; rvalid = 1'b1;
    @(negedge clk);
    rvalid = 1'b0;
    @(negedge clk);
    axi.i_arready = 1'b1;
    @(negedge clk);
    axi.i_arready = 1'b0; axi.i_rvalid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rst_mid", 32'(obs), 32'(idle_o));
    axi.i_rlast = 1'b1;
    @(negedge clk);
    chk("rst_mid_hold", 32'(obs), 32'(idle_o));
    rst = 1'b0; axi.i_rvalid = 1'b0; axi.i_rlast = 1'b0;
    #1 chk("rst_after", 32'(obs), 32'(idle_o));
    @(negedge clk);
    #1 chk("rst_no_write", 32'(obs), 32'(idle_o));
    @(negedge clk);

    miss(32'h0000_1FFC, 4'b0001, 0, 5, 32'h0000_1FF0);

`ifdef ICACHE_CACOP_EN
    cacop_req = 1'b1; cacop_way = 4'b1000; rvalid = 1'b1;
    #1 chk("c_idle", 32'(obs), 32'(idle_o));
    @(negedge clk);
    #1 chk("cacop", 32'(obs), 32'(eo(L, L, L, L, 4'h0, L, L, 4'h0, 4'b1000, H, H, L, L)));
    @(negedge clk);
    cacop_req = 1'b0;
    #1 chk("c_after", 32'(obs), 32'(idle_o));
    @(negedge clk);
    hit = 4'b0001; rvalid = 1'b0;
    #1 chk("c_lookup", 32'(obs), 32'(eo(H, H, H, H, 4'b0001, L, L, 4'h0, 4'h0, L, L, L, L)));
    @(negedge clk);
`else
    cacop_req = 1'b1; cacop_way = 4'b1000; rvalid = 1'b1;
    #1 chk("nc_idle", 32'(obs), 32'(idle_o));
    @(negedge clk);
    hit = 4'b0001; rvalid = 1'b0;
    #1 chk("nc_lookup", 32'(obs), 32'(eo(H, H, H, H, 4'b0001, L, L, 4'h0, 4'h0, L, L, L, L)));
    @(negedge clk);
    cacop_req = 1'b0;
    #1 chk("nc_idle2", 32'(obs), 32'(idle_o));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/icache_ctrl_nway.md
# icache_ctrl_nway

Parametrised control FSM for the instruction cache, the next generation of the two-way icache controller. It sequences lookup, AXI-style burst refill, uncached single-beat fetch, and optional CACOP index-invalidate for an N-way, multi-word-line icache. It sits between the IF-stage request buffer and the AXI read master, and drives the tag/valid RAM, data RAM, fill buffer and LRU write controls.

## Interface
Parameters:
- NUM_WAYS, 2: associativity; power of two, 2..8
- LINE_WORDS, 4: 32-bit words per line; power of two, 2..16
- ADDR_W, 32: address width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- rvalid  in  1  fetch request from IF
- rready  out  1  request accepted / data returned
- addr  in  ADDR_W  request-buffer address, held stable while not IDLE
- uncache  in  1  request is uncached, sampled in LOOKUP
- hit  in  NUM_WAYS  one-hot tag compare result, valid in LOOKUP
- repl_way  in  NUM_WAYS  one-hot victim from replacement logic
- i_arvalid / i_arready  out / in  1  read address handshake
- i_araddr  out  ADDR_W  burst start address
- i_arlen  out  8  beats minus one
- i_rvalid / i_rready / i_rlast  in / out / in  1  read data handshake
- fbuf_we  out  1  fill-buffer beat write
- fbuf_idx  out  log2(LINE_WORDS)  fill-buffer word index
- fbuf_clear  out  1  clear fill buffer
- rbuf_we  out  1  load request buffer
- data_from_mem_sel  out  1  1 = return data from fill buffer / bus
- mem_we  out  NUM_WAYS  data RAM line write
- tagv_we  out  NUM_WAYS  tag/valid write
- tagv_clr  out  1  write valid=0 instead of new tag
- lru_update  out  1  touch LRU
- lru_way  out  NUM_WAYS  one-hot way to touch
- cacop_req  in  1  index-invalidate request
- cacop_way  in  NUM_WAYS  one-hot target way
- cacop_ack  out  1  one-cycle invalidate done

## Operation
States: IDLE, LOOKUP, MISS_A, MISS_R, REFILL, CACOP.
- IDLE: rready=1, rbuf_we=1, fbuf_clear=1. cacop_req → CACOP (priority over rvalid). Else rvalid → LOOKUP.
- LOOKUP:
  - uncache → MISS_A.
  - hit≠0 → rready=1, rbuf_we=1, data_from_mem_sel=0, lru_update=1, lru_way=hit, fbuf_clear=1. Next state is LOOKUP if rvalid, else IDLE.
  - hit=0 → MISS_A. The victim is latched from repl_way into an internal way register.
  - On leaving LOOKUP for MISS_A, the internal araddr/arlen registers load:
    - uncached: {addr[ADDR_W-1:2],2'b0}, arlen 0.
    - cached: addr aligned to the line, arlen LINE_WORDS-1.
  - The internal uncache flag also latches at this point.
- MISS_A: i_arvalid=1. i_araddr and i_arlen come from the registers and stay stable until i_arready. → MISS_R on i_arready.
- MISS_R: i_rready=1.
  - Each i_rvalid beat: fbuf_we=1, fbuf_idx = beat counter, counter increments.
  - Beats beyond LINE_WORDS: fbuf_we=0 and the counter saturates.
  - i_rvalid&&i_rlast: uncached → rready=1, data_from_mem_sel=1 in that cycle, → IDLE. Cached → REFILL.
  - Termination is decided by i_rlast only.
- REFILL (1 cycle): mem_we = tagv_we = latched way. rready=1, data_from_mem_sel=1 (requested word from fill buffer). lru_update=1, lru_way = latched way. → IDLE.
- CACOP (1 cycle): tagv_we=cacop_way, tagv_clr=1, cacop_ack=1. → IDLE.
- cacop_req arriving outside IDLE is held by its source until ack.
- Every output not listed for a state is 0.

## Timing
- Outputs are decoded combinationally from state and inputs. i_araddr, i_arlen, the latched way, the uncache flag and the beat counter are registers.
- Reset: state IDLE, counter 0, all registers 0. While in reset the outputs take their IDLE values: rready=1, rbuf_we=1, fbuf_clear=1, everything else 0.
- Hit latency: request to rready is 1 cycle (IDLE→LOOKUP). Back-to-back hits sustain 1 per cycle.
- Cached miss: LOOKUP + MISS_A (≥1) + LINE_WORDS beats + REFILL.
- Reset mid-burst returns to IDLE with no RAM write. The bus is reset with the core.
- i_rvalid before the AR handshake is a protocol error and is ignored (i_rready=0).

## Configuration
- ICACHE_CACOP_EN defined: CACOP state and ports are active as described.
- Undefined: CACOP state is absent, cacop_req is ignored, and cacop_ack=0 and tagv_clr=0 constantly.

## Structure
- Shared package icache_pkg holds the state enum encoding, the AXI_LEN_W=8 constant, and the line-offset width function.
- One sub-module: icache_beat_cnt (saturating beat counter with fbuf_idx output).

## Test plan
- Back-to-back hits, NUM_WAYS=4, hit=4'b0100 for 3 requests → rready=1 each cycle, lru_way=4'b0100 ×3, i_arvalid never set.
- Cached miss, LINE_WORDS=4, addr=0x1C00_0234, repl_way=4'b0010, i_arready delayed 2 cycles:
  - i_araddr=0x1C00_0230, arlen=3 held stable through the delay.
  - fbuf_idx 0..3 on the 4 beats.
  - REFILL: mem_we=tagv_we=4'b0010, rready=1.
- Uncached, addr=0xBFAF_F006 → i_araddr=0xBFAF_F004, arlen=0. rready=1 in the same cycle as the rlast beat. REFILL is never entered.
- Simultaneous cacop_req and rvalid in IDLE, cacop_way=4'b1000 → CACOP first: tagv_we=4'b1000, tagv_clr=1, cacop_ack=1. LOOKUP follows.
- rst asserted during beat 2 of a refill → state is IDLE immediately. No mem_we/tagv_we pulse. IDLE output values appear.
